// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM for the load/store path with byte-lane
// stores, sized/sign-extended loads and a fixed read latency. Optional DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic              Busy
`ifdef DMEM_MISALIGN_CHECK_EN
  , output logic            Misaligned
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [2:0]       f3;
    logic             mis;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mis_q, mis_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W-1:0]  wr_idx;
  logic              mis_wr;
  logic              mis_rd;

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    store_be = 4'b0001 << lo;
      F3_H:    store_be = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Select and extend the addressed byte/half of a word.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    load_extract = {{24{b[7]}}, b};
      F3_H:    load_extract = {{16{h[15]}}, h};
      F3_W:    load_extract = w;
      F3_BU:   load_extract = {24'h0, b};
      F3_HU:   load_extract = {16'h0, h};
      default: load_extract = '0;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_wr = ((Funct3 == F3_H) && Addr[0]) ||
                  ((Funct3 == F3_W) && (Addr[1:0] != 2'b00));
  assign mis_rd = (((Funct3 == F3_H) || (Funct3 == F3_HU)) && Addr[0]) ||
                  ((Funct3 == F3_W) && (Addr[1:0] != 2'b00));
`else
  assign mis_wr = 1'b0;
  assign mis_rd = 1'b0;
`endif

  // Store path: only IDLE stores commit; stores seen during WAIT are ignored.
  assign wr_en   = reset && (state_q == ST_IDLE) && MemWrite && !mis_wr;
  assign wr_be   = store_be(Funct3, Addr[1:0]);
  assign wr_idx  = Addr[IDX_W+1:2];
  assign wr_data = (Funct3 == F3_B) ? {4{WrData[7:0]}} :
                   (Funct3 == F3_H) ? {2{WrData[15:0]}} : WrData;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Stall while a read is being accepted or is in flight; never during reset.
  assign Busy = reset && (((state_q == ST_IDLE) && MemRead && !MemWrite) ||
                          (state_q == ST_WAIT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemWrite) begin
          mis_d = mis_wr;
        end else if (MemRead) begin
          req_d.idx  = Addr[IDX_W+1:2];
          req_d.lane = Addr[1:0];
          req_d.f3   = Funct3;
          req_d.mis  = mis_rd;
          cnt_d      = CNT_W'(RD_LAT - 1);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rd_data_d  = req_q.mis ? '0 : load_extract(mem[req_q.idx], req_q.f3, req_q.lane);
          rd_valid_d = 1'b1;
          mis_d      = req_q.mis;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      mis_q      <= mis_d;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign Misaligned = mis_q;
`endif

  // Address bits above the RAM index wrap away by design.
  logic unused_ok;
  assign unused_ok = &{1'b0, Addr[31:IDX_W+2], mis_q};

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (default configuration);
// expected load data comes from a byte-array memory model and directed constants.
module tb_data_mem_responder;

  localparam int unsigned RD_LAT = 2;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        RdValid;
  logic        Busy;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        Misaligned;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .DEPTH(256), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .RdValid  (RdValid),
    .Busy     (Busy)
`ifdef DMEM_MISALIGN_CHECK_EN
    , .Misaligned (Misaligned)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  bmem [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every RdValid pulse consumes one expected load result.
  always @(negedge clk) begin
    if (RdValid === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_rdvalid", 32'd1, 32'd0);
      else check("rd_data", RdData, exp_q.pop_front());
    end
  end

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [9:0] p;
    p = a[9:0];
    case (f3)
      F3_B: bmem[p] = d[7:0];
      F3_H: begin
        p[0] = 1'b0;
        bmem[p] = d[7:0];
        bmem[10'(p + 1)] = d[15:8];
      end
      F3_W: begin
        p[1:0] = 2'b00;
        for (int k = 0; k < 4; k++) bmem[10'(p + k)] = d[8*k +: 8];
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [9:0]  p;
    logic [15:0] h;
    p = a[9:0];
    model_load = 32'h0;
    case (f3)
      F3_B:  model_load = {{24{bmem[p][7]}}, bmem[p]};
      F3_BU: model_load = {24'h0, bmem[p]};
      F3_H, F3_HU: begin
        p[0] = 1'b0;
        h = {bmem[10'(p + 1)], bmem[p]};
        model_load = (f3 == F3_H) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      F3_W: begin
        p[1:0] = 2'b00;
        model_load = {bmem[10'(p + 3)], bmem[10'(p + 2)], bmem[10'(p + 1)], bmem[p]};
      end
      default: model_load = 32'h0;
    endcase
  endfunction

  task automatic idle_inputs();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Funct3   = 3'b000;
    Addr     = 32'h0;
    WrData   = 32'h0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    Funct3   = f3;
    Addr     = a;
    WrData   = d;
    #1 check("store_busy", 32'(Busy), 32'd0);
    model_store(f3, a, d);
    @(negedge clk);
    idle_inputs();
  endtask

  // Issue a load, scramble inputs during WAIT, and check the Busy/RdValid timeline.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    @(negedge clk);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Funct3   = f3;
    Addr     = a;
    exp_q.push_back(exp);
    #1 check({tag, "_busy_req"}, 32'(Busy), 32'd1);
    for (int c = 0; c < int'(RD_LAT); c++) begin
      @(negedge clk);
      MemRead = 1'($urandom_range(0, 1));
      Funct3  = 3'($urandom);
      Addr    = $urandom;
      #1 check({tag, "_busy_wait"}, 32'(Busy), 32'd1);
      check({tag, "_early_valid"}, 32'(RdValid), 32'd0);
    end
    @(negedge clk);
    idle_inputs();
    #1 check({tag, "_valid"}, 32'(RdValid), 32'd1);
    check({tag, "_busy_done"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  ld_f3s [6];
    ld_f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, 3'b011};

    // Reset held with a load request pending
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    MemRead = 1'b1;
    Funct3  = F3_W;
    #1 check("reset_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    #1 check("reset_rdvalid", 32'(RdValid), 32'd0);
    check("reset_rddata", RdData, 32'h0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    // SW then LW
    do_store(F3_W, 32'h10, 32'hDEADBEEF);
    do_load("lw10", F3_W, 32'h10, 32'hDEADBEEF);

    // Address change and a store during WAIT are ignored; back-to-back accept
    do_store(F3_W, 32'h20, 32'h12345678);
    @(negedge clk);
    MemRead = 1'b1;
    Funct3  = F3_W;
    Addr    = 32'h10;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    Addr     = 32'h20;
    WrData   = 32'h00000BAD;
    #1 check("b2b_busy_wait", 32'(Busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Addr     = 32'h20;
    exp_q.push_back(32'h12345678);
    #1 check("b2b_valid1", 32'(RdValid), 32'd1);
    check("b2b_accept_busy", 32'(Busy), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1 check("b2b_wait_busy", 32'(Busy), 32'd1);
    check("b2b_no_valid", 32'(RdValid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 check("b2b_valid2", 32'(RdValid), 32'd1);

    // SB and sized loads
    do_store(F3_B, 32'h13, 32'h00000080);
    do_load("lb13", F3_B, 32'h13, 32'hFFFFFF80);
    do_load("lbu13", F3_BU, 32'h13, 32'h00000080);
    do_load("lhu12", F3_HU, 32'h12, 32'h000080AD);
    do_load("lh12", F3_H, 32'h12, 32'hFFFF80AD);
    do_load("lh10", F3_H, 32'h10, 32'hFFFFBEEF);
    do_load("lb10", F3_B, 32'h10, 32'hFFFFFFEF);
    do_load("lbad", 3'b011, 32'h10, 32'h0);
    do_store(F3_H, 32'h16, 32'h0000A55A);
    do_load("lw14_sh", F3_W, 32'h14, model_load(F3_W, 32'h14));

    // Simultaneous read and write: write wins, read dropped; address alias
    @(negedge clk);
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    Funct3   = F3_W;
    Addr     = 32'h0;
    WrData   = 32'h1;
    #1 check("rw_busy", 32'(Busy), 32'd0);
    model_store(F3_W, 32'h0, 32'h1);
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check("rw_no_valid", 32'(RdValid), 32'd0);
    end
    do_load("alias400", F3_W, 32'h400, 32'h00000001);

    // Reset while WAITing aborts the read
    @(negedge clk);
    MemRead = 1'b1;
    Funct3  = F3_W;
    Addr    = 32'h10;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1 check("abort_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_rddata", RdData, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check("abort_no_valid", 32'(RdValid), 32'd0);
    end

    // Randomised traffic against the byte model
    for (int w = 0; w < 16; w++) do_store(F3_W, 32'(w * 4), $urandom);
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 7)) << 10);
      if ($urandom_range(0, 2) == 0) begin
        f3 = 3'($urandom_range(0, 2));
        d  = $urandom;
        do_store(f3, a, d);
      end else begin
        f3 = ld_f3s[$urandom_range(0, 5)];
        do_load("rnd", f3, a, model_load(f3, a));
      end
    end

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    #2 check("pending_loads", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
